// File: rtl/cvxif_pkg.sv
// Shared types for the coprocessor datapath: the convolution job descriptor and
// the systolic-array sequencer state, array geometry and pipeline depths.
package cvxif_pkg;

    localparam int unsigned SA_ROWS     = 9;
    localparam int unsigned SA_DEPTH_K1 = 3;
    localparam int unsigned SA_DEPTH_K3 = 9;
    localparam int unsigned SA_CNT_W    = 16;
    localparam int unsigned SA_TAP_W    = $clog2(SA_ROWS);

    typedef struct packed {
        logic [1:0]          W_width;
        logic [SA_CNT_W-1:0] n_pix;
    } convolution;

    typedef enum logic [2:0] {
        SA_IDLE,
        SA_LOAD,
        SA_STREAM,
        SA_DRAIN,
        SA_DONE
    } sa_ctrl_state_e;

    // Index of the valid-pipe tap that lines up with the array output row.
    function automatic logic [SA_TAP_W-1:0] sa_last_tap(input logic [1:0] w_width);
        return (w_width == 2'd1) ? SA_TAP_W'(SA_DEPTH_K1 - 1) : SA_TAP_W'(SA_DEPTH_K3 - 1);
    endfunction

endpackage

// File: rtl/sa_valid_pipe.sv
// Beat tracker that moves in lock-step with the PE rows: one bit per row, shifted
// only when the array advances, with a selectable output tap.
module sa_valid_pipe
    import cvxif_pkg::*;
#(
    parameter int unsigned ROWS  = SA_ROWS,
    parameter int unsigned TAP_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             adv,
    input  logic             din,
    input  logic [TAP_W-1:0] tap,
    output logic             fresh,
    output logic             pending
);

    logic [ROWS-1:0] pipe_q;
    logic            adv_q;
    logic [ROWS-1:0] below_mask;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_q <= '0;
            adv_q  <= 1'b0;
        end else if (clr) begin
            pipe_q <= '0;
            adv_q  <= 1'b0;
        end else begin
            adv_q <= adv;
            if (adv) begin
                pipe_q <= {pipe_q[ROWS-2:0], din};
            end
        end
    end

    // Rows strictly before the output tap still hold beats that need advancing.
    always_comb begin
        below_mask = (ROWS'(1) << tap) - ROWS'(1);
    end

    assign pending = |(pipe_q & below_mask);
    // A tap bit only counts in the cycle right after an advance, so a stall never repeats it.
    assign fresh   = pipe_q[tap] & adv_q;

endmodule

// File: rtl/sa_ctrl.sv
// Job sequencer for the weight-stationary systolic array: weight load, input
// streaming with stall gating, drain, and result-valid tracking through the rows.
module sa_ctrl
    import cvxif_pkg::*;
#(
    parameter int unsigned ROWS  = SA_ROWS,
    parameter int unsigned CNT_W = SA_CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [1:0]       cfg_kernel_i,
    input  logic [CNT_W-1:0] cfg_npix_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             stop_i,
    output logic             load_en_o,
    output logic             acc_en_o,
    output logic             res_valid_o,
    output logic             res_last_o,
    output logic [CNT_W-1:0] res_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned TAP_W = $clog2(ROWS);

    sa_ctrl_state_e   state_q, state_d;
    convolution       job_q;
    logic [CNT_W-1:0] issued_q;
    logic [CNT_W-1:0] res_idx_q;
    logic [CNT_W-1:0] npix;
    logic [CNT_W-1:0] last_idx;
    logic [TAP_W-1:0] tap;
    logic             cfg_fire;
    logic             beat_fire;
    logic             abort;
    logic             pipe_clr;
    logic             pipe_din;
    logic             fresh;
    logic             pending;

    assign npix      = CNT_W'(job_q.n_pix);
    assign last_idx  = npix - CNT_W'(1);
    assign tap       = TAP_W'(sa_last_tap(job_q.W_width));
    assign cfg_fire  = cfg_valid_i && (state_q == SA_IDLE);
    assign abort     = stop_i && (state_q != SA_IDLE);
    assign beat_fire = in_valid_i && in_ready_o;
    assign pipe_clr  = cfg_fire || abort;

    assign busy_o      = (state_q != SA_IDLE);
    assign res_valid_o = fresh;
    assign res_last_o  = fresh && (res_idx_q == last_idx);
    assign res_idx_o   = res_idx_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SA_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and array enables; an abort gates the enables in the same cycle.
    always_comb begin
        state_d     = state_q;
        cfg_ready_o = 1'b0;
        in_ready_o  = 1'b0;
        load_en_o   = 1'b0;
        acc_en_o    = 1'b0;
        done_o      = 1'b0;
        pipe_din    = 1'b0;
        case (state_q)
            SA_IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) begin
                    state_d = SA_LOAD;
                end
            end
            SA_LOAD: begin
                load_en_o = 1'b1;
                state_d   = (npix == '0) ? SA_DONE : SA_STREAM;
            end
            SA_STREAM: begin
                in_ready_o = 1'b1;
                acc_en_o   = in_valid_i;
                pipe_din   = 1'b1;
                if (in_valid_i && (issued_q == last_idx)) begin
                    state_d = SA_DRAIN;
                end
            end
            SA_DRAIN: begin
                acc_en_o = pending;
                if (res_last_o) begin
                    state_d = SA_DONE;
                end
            end
            SA_DONE: begin
                done_o  = 1'b1;
                state_d = SA_IDLE;
            end
            default: begin
                state_d = SA_IDLE;
            end
        endcase
        if (abort) begin
            state_d   = SA_IDLE;
            load_en_o = 1'b0;
            acc_en_o  = 1'b0;
        end
    end

    // Job descriptor and beat/result counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            job_q     <= '0;
            issued_q  <= '0;
            res_idx_q <= '0;
        end else if (cfg_fire) begin
            job_q.W_width <= cfg_kernel_i;
            job_q.n_pix   <= SA_CNT_W'(cfg_npix_i);
            issued_q      <= '0;
            res_idx_q     <= '0;
        end else if (abort) begin
            issued_q  <= '0;
            res_idx_q <= '0;
        end else begin
            if (beat_fire) begin
                issued_q <= issued_q + CNT_W'(1);
            end
            if (fresh) begin
                res_idx_q <= res_idx_q + CNT_W'(1);
            end
        end
    end

    sa_valid_pipe #(
        .ROWS  (ROWS),
        .TAP_W (TAP_W)
    ) u_valid_pipe (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (pipe_clr),
        .adv     (acc_en_o),
        .din     (pipe_din),
        .tap     (tap),
        .fresh   (fresh),
        .pending (pending)
    );

endmodule

// File: tb/tb_sa_ctrl.sv
// Self-checking bench for sa_ctrl: table of jobs with a result scoreboard, plus
// hand-written abort and mid-job reset sequences.
module tb_sa_ctrl;

    localparam int unsigned CNT_W = 16;

    typedef struct {
        logic [1:0] kernel;
        int         npix;
        int         stall;
        int         exp_done;
        int         exp_acc;
    } vec_t;

    typedef struct {
        int cyc;
        int idx;
        bit last;
    } exp_t;

    logic             clk;
    logic             rstn;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_kernel;
    logic [CNT_W-1:0] cfg_npix;
    logic             in_valid;
    logic             in_ready;
    logic             stop;
    logic             load_en;
    logic             acc_en;
    logic             res_valid;
    logic             res_last;
    logic [CNT_W-1:0] res_idx;
    logic             busy;
    logic             done;

    int   n_checks;
    int   n_pass;
    int   cyc;
    int   t0;
    int   acc_cnt;
    int   load_cnt;
    int   load_cyc;
    int   done_cnt;
    int   done_cyc;
    exp_t sb[$];
    vec_t tbl[9];

    sa_ctrl #(.ROWS(9), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_kernel_i (cfg_kernel),
        .cfg_npix_i   (cfg_npix),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .stop_i       (stop),
        .load_en_o    (load_en),
        .acc_en_o     (acc_en),
        .res_valid_o  (res_valid),
        .res_last_o   (res_last),
        .res_idx_o    (res_idx),
        .busy_o       (busy),
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Array model: the rows advance on every non-stalled cycle from the first
    // stream cycle; result i leaves the array after D advances of its beat.
    function automatic void push_expected(input vec_t v);
        int d;
        int beats;
        int t;
        int acc[$];
        exp_t e;
        d = (v.kernel == 2'd1) ? 3 : 9;
        beats = 0;
        t = 2;
        if (v.npix == 0) return;
        while (acc.size() < v.npix + d) begin
            if (beats < v.npix) begin
                if (t != v.stall) begin
                    acc.push_back(t);
                    beats++;
                end
            end else begin
                acc.push_back(t);
            end
            t++;
        end
        for (int i = 0; i < v.npix; i++) begin
            e.cyc  = acc[i + d - 1] + 1;
            e.idx  = i;
            e.last = (i == v.npix - 1);
            sb.push_back(e);
        end
    endfunction

    // Output monitor sampled on the falling edge.
    always @(negedge clk) begin
        int   rel;
        exp_t e;
        rel = cyc - t0;
        if (acc_en) acc_cnt++;
        if (load_en) begin
            load_cnt++;
            load_cyc = rel;
        end
        if (done) begin
            done_cnt++;
            done_cyc = rel;
        end
        if (res_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_result: res_valid at cycle %0d idx %0d, expected none", rel, res_idx);
            end else begin
                e = sb.pop_front();
                if (rel == e.cyc && int'(res_idx) == e.idx && res_last == e.last) n_pass++;
                else $display("FAIL result: got cycle %0d idx %0d last %0d, expected cycle %0d idx %0d last %0d",
                              rel, res_idx, res_last, e.cyc, e.idx, e.last);
            end
        end
    end

    task automatic clear_stats();
        t0       = cyc;
        acc_cnt  = 0;
        load_cnt = 0;
        load_cyc = -1;
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic run_job(input vec_t v);
        int r;
        clear_stats();
        push_expected(v);
        cfg_valid  = 1'b1;
        cfg_kernel = v.kernel;
        cfg_npix   = CNT_W'(v.npix);
        in_valid   = (v.stall != 0);
        r = 0;
        while (done_cnt == 0 && r < 60) begin
            @(posedge clk); #1;
            r++;
            cfg_valid = 1'b0;
            in_valid  = (r != v.stall);
        end
        chk("done_cycle", done_cyc, v.exp_done);
        chk("acc_count", acc_cnt, v.exp_acc);
        chk("load_cycle", load_cyc, 1);
        chk("load_count", load_cnt, 1);
        chk("pending_results", sb.size(), 0);
        chk("idle_after_done", int'(busy), 0);
        sb.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_load_en"}, int'(load_en), 0);
        chk({tag, "_acc_en"}, int'(acc_en), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_res_last"}, int'(res_last), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_res_idx"}, int'(res_idx), 0);
    endtask

    initial begin
        vec_t v;
        n_checks   = 0;
        n_pass     = 0;
        cyc        = 0;
        t0         = 0;
        rstn       = 1'b0;
        cfg_valid  = 1'b0;
        cfg_kernel = 2'd0;
        cfg_npix   = '0;
        in_valid   = 1'b0;
        stop       = 1'b0;
        clear_stats();

        //           kernel npix stall done acc
        tbl[0] = '{2'd3, 4, -1, 15, 12};
        tbl[1] = '{2'd1, 4, -1,  9,  6};
        tbl[2] = '{2'd3, 4,  3, 16, 12};
        tbl[3] = '{2'd3, 0, -1,  2,  0};
        tbl[4] = '{2'd1, 1, -1,  6,  3};
        tbl[5] = '{2'd2, 1, -1, 12,  9};
        tbl[6] = '{2'd1, 5,  4, 11,  7};
        tbl[7] = '{2'd1, 4,  5, 10,  6};
        tbl[8] = '{2'd1, 2, -1,  7,  4};

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        #1 chk_reset_outputs("reset");

        for (int i = 0; i < 8; i++) begin
            run_job(tbl[i]);
        end

        // Abort a kernel=3, N=8 job at cycle 6, with an ignored offer at cycle 3.
        clear_stats();
        cfg_valid  = 1'b1;
        cfg_kernel = 2'd3;
        cfg_npix   = CNT_W'(8);
        in_valid   = 1'b1;
        for (int r = 1; r <= 6; r++) begin
            @(posedge clk); #1;
            cfg_valid = (r == 3);
            cfg_npix  = (r == 3) ? CNT_W'(2) : CNT_W'(8);
            if (r == 3) begin
                #1 chk("cfg_ready_while_busy", int'(cfg_ready), 0);
            end
        end
        cfg_valid = 1'b0;
        stop = 1'b1;
        #1 chk("acc_en_on_stop", int'(acc_en), 0);
        chk("load_en_on_stop", int'(load_en), 0);
        @(posedge clk); #1;
        stop = 1'b0;
        chk("busy_after_stop", int'(busy), 0);
        chk("cfg_ready_after_stop", int'(cfg_ready), 1);
        chk("acc_count_stopped", acc_cnt, 4);
        chk("done_count_stopped", done_cnt, 0);
        run_job(tbl[8]);

        // Reset in the middle of a kernel=1, N=8 job; results 0..2 come out first.
        clear_stats();
        v = '{2'd1, 8, -1, 0, 0};
        push_expected(v);
        cfg_valid  = 1'b1;
        cfg_kernel = 2'd1;
        cfg_npix   = CNT_W'(8);
        in_valid   = 1'b1;
        for (int r = 1; r <= 8; r++) begin
            @(posedge clk); #1;
            cfg_valid = 1'b0;
        end
        #1 chk("busy_before_reset", int'(busy), 1);
        chk("res_idx_before_reset", int'(res_idx), 3);
        rstn = 1'b0;
        #1 chk_reset_outputs("async_reset");
        chk("results_before_reset", 8 - sb.size(), 3);
        sb.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        #1 chk("cfg_ready_after_release", int'(cfg_ready), 1);
        chk("busy_after_release", int'(busy), 0);
        run_job(tbl[0]);

        repeat (12) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
